// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage_pkg
// Shared opcode constants and control-bundle layout for decoder and ID/EX.
// Rev    : 1.0
// ============================================================================
package id_ex_stage_pkg;

   typedef enum logic [6:0] {
      c_op_load   = 7'b0000011,
      c_op_store  = 7'b0100011,
      c_op_immalu = 7'b0010011,
      c_op_regalu = 7'b0110011,
      c_op_pause  = 7'b1110011
   } opcode_t;

   localparam logic [3:0] c_alu_add  = 4'b0000;
   localparam int         c_ctrl_w   = 11;

   // Field order is MSB first; the decoder packs with ctrl_pack so both agree.
   typedef struct packed {
      logic       memtoreg;
      logic       memwrite;
      logic       alusrcimm;
      logic       writesreg;
      logic       jump;
      logic       pause;
      logic       splitimm;
      logic [3:0] aluop;
   } ctrl_t;

   function automatic ctrl_t ctrl_pack(
      input logic       memtoreg,
      input logic       memwrite,
      input logic       alusrcimm,
      input logic       writesreg,
      input logic       jump,
      input logic       pause,
      input logic       splitimm,
      input logic [3:0] aluop
   );
      ctrl_t c;
      c.memtoreg  = memtoreg;
      c.memwrite  = memwrite;
      c.alusrcimm = alusrcimm;
      c.writesreg = writesreg;
      c.jump      = jump;
      c.pause     = pause;
      c.splitimm  = splitimm;
      c.aluop     = aluop;
      return c;
   endfunction

   function automatic ctrl_t main_decode(input opcode_t op);
      ctrl_t c;
      c = '0;
      case (op)
         c_op_load:   c = ctrl_pack(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c_alu_add);
         c_op_store:  c = ctrl_pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_alu_add);
         c_op_immalu: c = ctrl_pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c_alu_add);
         c_op_regalu: c = ctrl_pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c_alu_add);
         c_op_pause:  c = ctrl_pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c_alu_add);
         default:     c = '0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module : id_ex_if
// Decode-to-execute bundle plus EX handshake, flush and status signals.
// Rev    : 1.0
// ============================================================================
interface id_ex_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 32
) ();
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic [REGW-1:0] id_rd;
   logic [XLEN-1:0] id_rd1;
   logic [XLEN-1:0] id_rd2;
   logic [XLEN-1:0] id_imm;
   logic            id_memtoreg;
   logic            id_memwrite;
   logic            id_alusrcimm;
   logic            id_writesreg;
   logic            id_jump;
   logic            id_pause;
   logic            id_splitimm;
   logic [3:0]      id_aluop;
   logic            ex_ready;
   logic            flush;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rd1;
   logic [XLEN-1:0] ex_rd2;
   logic [XLEN-1:0] ex_imm;
   logic [REGW-1:0] ex_rs1;
   logic [REGW-1:0] ex_rs2;
   logic [REGW-1:0] ex_rd;
   logic            ex_memtoreg;
   logic            ex_memwrite;
   logic            ex_alusrcimm;
   logic            ex_writesreg;
   logic            ex_jump;
   logic            ex_pause;
   logic            ex_splitimm;
   logic [3:0]      ex_aluop;
   logic            halted;
   logic [CNTW-1:0] bubble_cnt;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
             id_memtoreg, id_memwrite, id_alusrcimm, id_writesreg, id_jump,
             id_pause, id_splitimm, id_aluop, ex_ready, flush,
      input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_memtoreg, ex_memwrite, ex_alusrcimm, ex_writesreg,
             ex_jump, ex_pause, ex_splitimm, ex_aluop, halted, bubble_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
             id_memtoreg, id_memwrite, id_alusrcimm, id_writesreg, id_jump,
             id_pause, id_splitimm, id_aluop, ex_ready, flush,
      output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_memtoreg, ex_memwrite, ex_alusrcimm, ex_writesreg,
             ex_jump, ex_pause, ex_splitimm, ex_aluop, halted, bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Combinational load-use check of the decode sources against the load in EX.
// Rev    : 1.0
// ============================================================================
module hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic            ex_valid,
   input  logic            ex_memtoreg,
   input  logic [REGW-1:0] ex_rd,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            id_alusrcimm,
   input  logic            id_memwrite,
   output logic            hazard,
   output logic            use_rs2
);
   logic w_load_in_ex;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // Stores read rs2 as data even though their ALU operand is the immediate.
   assign use_rs2      = ~id_alusrcimm | id_memwrite;
   assign w_load_in_ex = ex_valid & ex_memtoreg & (ex_rd != '0);
   assign w_rs1_hit    = (id_rs1 == ex_rd);
   assign w_rs2_hit    = use_rs2 & (id_rs2 == ex_rd);
   assign hazard       = w_load_in_ex & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage
// ID/EX boundary register with load-use bubbles, redirect flush and halt latch.
// Rev    : 1.0
// ============================================================================
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 32
) (
   input  logic   clk,
   input  logic   reset,
   id_ex_if.slave bus
);
   logic            r_valid;
   logic            r_halted;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rd1;
   logic [XLEN-1:0] r_rd2;
   logic [XLEN-1:0] r_imm;
   logic [REGW-1:0] r_rs1;
   logic [REGW-1:0] r_rs2;
   logic [REGW-1:0] r_rd;
   ctrl_t           r_ctrl;
   logic [CNTW-1:0] r_bubble_cnt;

   ctrl_t           w_id_ctrl;
   logic            w_advance;
   logic            w_hazard;
   logic            w_use_rs2_unused;
   logic            w_accept;
   logic            w_cnt_sat;

   assign w_id_ctrl = ctrl_pack(bus.id_memtoreg, bus.id_memwrite, bus.id_alusrcimm,
                                bus.id_writesreg, bus.id_jump, bus.id_pause,
                                bus.id_splitimm, bus.id_aluop);

   hazard_detect #(
      .REGW (REGW)
   ) u_hazard_detect (
      .ex_valid     (r_valid),
      .ex_memtoreg  (r_ctrl.memtoreg),
      .ex_rd        (r_rd),
      .id_rs1       (bus.id_rs1),
      .id_rs2       (bus.id_rs2),
      .id_alusrcimm (bus.id_alusrcimm),
      .id_memwrite  (bus.id_memwrite),
      .hazard       (w_hazard),
      .use_rs2      (w_use_rs2_unused)
   );

   assign w_advance    = bus.ex_ready | ~r_valid;
   assign bus.id_ready = ~reset & w_advance & ~w_hazard & ~r_halted & ~bus.flush;
   assign w_accept     = bus.id_valid & bus.id_ready;
   assign w_cnt_sat    = &r_bubble_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_halted     <= 1'b0;
         r_pc         <= '0;
         r_rd1        <= '0;
         r_rd2        <= '0;
         r_imm        <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_ctrl       <= '0;
         r_bubble_cnt <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (r_halted) begin
         // Frozen core: the pause bundle drains once EX takes it, nothing follows.
         if (bus.ex_ready) begin
            r_valid <= 1'b0;
         end
      end else if (w_advance) begin
         if (w_hazard && bus.id_valid) begin
            r_valid <= 1'b0;
            if (!w_cnt_sat) begin
               r_bubble_cnt <= r_bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
         end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_pc     <= bus.id_pc;
            r_rd1    <= bus.id_rd1;
            r_rd2    <= bus.id_rd2;
            r_imm    <= bus.id_imm;
            r_rs1    <= bus.id_rs1;
            r_rs2    <= bus.id_rs2;
            r_rd     <= bus.id_rd;
            r_ctrl   <= w_id_ctrl;
            r_halted <= bus.id_pause;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.ex_valid     = r_valid;
   assign bus.ex_pc        = r_pc;
   assign bus.ex_rd1       = r_rd1;
   assign bus.ex_rd2       = r_rd2;
   assign bus.ex_imm       = r_imm;
   assign bus.ex_rs1       = r_rs1;
   assign bus.ex_rs2       = r_rs2;
   assign bus.ex_rd        = r_rd;
   assign bus.ex_memtoreg  = r_ctrl.memtoreg;
   // Side-effecting controls are gated here so a bubble can never write.
   assign bus.ex_memwrite  = r_ctrl.memwrite & r_valid;
   assign bus.ex_writesreg = r_ctrl.writesreg & r_valid;
   assign bus.ex_alusrcimm = r_ctrl.alusrcimm;
   assign bus.ex_jump      = r_ctrl.jump;
   assign bus.ex_pause     = r_ctrl.pause;
   assign bus.ex_splitimm  = r_ctrl.splitimm;
   assign bus.ex_aluop     = r_ctrl.aluop;
   assign bus.halted       = r_halted;
   assign bus.bubble_cnt   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_stage
// Randomized and directed bench for id_ex_stage against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int XLEN    = 32;
   localparam int REGW    = 5;
   localparam int CNTW    = 4;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
      ctrl_t           c;
   } bun_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   id_ex_if #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) bus ();

   id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // reference model: what sits in EX, whether it is live, halt and bubble tally
   bun_t m_ex;
   bit   m_valid;
   bit   m_halted;
   int   m_bub;

   bun_t            s_in;
   bit              s_valid, s_exrdy, s_flush, last_acc;
   logic [XLEN-1:0] next_pc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic ctrl_t ctl(bit mtr, bit mw, bit im, bit wr, bit jp, bit ps, bit sp, logic [3:0] op);
      ctrl_t c;
      c.memtoreg = mtr; c.memwrite = mw; c.alusrcimm = im; c.writesreg = wr;
      c.jump = jp; c.pause = ps; c.splitimm = sp; c.aluop = op;
      return c;
   endfunction

   function automatic bun_t mk(opcode_t op, int rd, int rs1, int rs2, int imm, logic [3:0] aop);
      bun_t b;
      b     = '0;
      b.rd  = REGW'(rd);
      b.rs1 = REGW'(rs1);
      b.rs2 = REGW'(rs2);
      b.imm = XLEN'(imm);
      b.rd1 = XLEN'($urandom);
      b.rd2 = XLEN'($urandom);
      case (op)
         c_op_load:   b.c = ctl(1, 0, 1, 1, 0, 0, 0, 4'b0000);
         c_op_store:  b.c = ctl(0, 1, 1, 0, 0, 0, 1, 4'b0000);
         c_op_immalu: b.c = ctl(0, 0, 1, 1, 0, 0, 0, aop);
         c_op_regalu: b.c = ctl(0, 0, 0, 1, 0, 0, 0, aop);
         default:     b.c = ctl(0, 0, 0, 0, 0, 1, 0, 4'b0000);
      endcase
      return b;
   endfunction

   function automatic bun_t rand_instr();
      bun_t b;
      opcode_t ops [4] = '{c_op_load, c_op_store, c_op_immalu, c_op_regalu};
      b = mk(ops[$urandom_range(0, 3)], $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), int'($urandom), 4'($urandom_range(0, 15)));
      if (b.c.alusrcimm && !b.c.memtoreg && !b.c.memwrite)
         b.c.jump = ($urandom_range(0, 5) == 0);
      return b;
   endfunction

   task automatic present(input bun_t b);
      s_in    = b;
      s_in.pc = next_pc;
      next_pc = next_pc + 4;
      s_valid = 1'b1;
   endtask

   task automatic drive();
      bus.id_valid     = s_valid;
      bus.id_pc        = s_in.pc;
      bus.id_rs1       = s_in.rs1;
      bus.id_rs2       = s_in.rs2;
      bus.id_rd        = s_in.rd;
      bus.id_rd1       = s_in.rd1;
      bus.id_rd2       = s_in.rd2;
      bus.id_imm       = s_in.imm;
      bus.id_memtoreg  = s_in.c.memtoreg;
      bus.id_memwrite  = s_in.c.memwrite;
      bus.id_alusrcimm = s_in.c.alusrcimm;
      bus.id_writesreg = s_in.c.writesreg;
      bus.id_jump      = s_in.c.jump;
      bus.id_pause     = s_in.c.pause;
      bus.id_splitimm  = s_in.c.splitimm;
      bus.id_aluop     = s_in.c.aluop;
      bus.ex_ready     = s_exrdy;
      bus.flush        = s_flush;
   endtask

   // A live load in EX whose destination the incoming instruction reads.
   function automatic bit load_conflict();
      bit reads2 = !s_in.c.alusrcimm || s_in.c.memwrite;
      return m_valid && m_ex.c.memtoreg && (m_ex.rd != 0) &&
             ((s_in.rs1 == m_ex.rd) || (reads2 && (s_in.rs2 == m_ex.rd)));
   endfunction

   function automatic bit exp_ready();
      return !reset && (s_exrdy || !m_valid) && !load_conflict() && !m_halted && !s_flush;
   endfunction

   task automatic model_edge();
      bit conflict = load_conflict();
      bit moves    = s_exrdy || !m_valid;
      last_acc = s_valid && exp_ready();
      if (last_acc) begin
         m_ex    = s_in;
         m_valid = 1'b1;
         if (s_in.c.pause) m_halted = 1'b1;
      end else if (s_flush) begin
         m_valid = 1'b0;
      end else if (m_halted) begin
         if (s_exrdy) m_valid = 1'b0;
      end else if (moves) begin
         m_valid = 1'b0;
         if (s_valid && conflict && m_bub < CNT_MAX) m_bub++;
      end
   endtask

   task automatic check_outputs();
      check("ex_valid", bus.ex_valid, m_valid);
      check("halted", bus.halted, m_halted);
      check("bubble_cnt", bus.bubble_cnt, m_bub);
      check("ex_memwrite", bus.ex_memwrite, m_valid & m_ex.c.memwrite);
      check("ex_writesreg", bus.ex_writesreg, m_valid & m_ex.c.writesreg);
      check("ex_memtoreg", bus.ex_memtoreg, m_ex.c.memtoreg);
      check("ex_alusrcimm", bus.ex_alusrcimm, m_ex.c.alusrcimm);
      check("ex_jump", bus.ex_jump, m_ex.c.jump);
      check("ex_pause", bus.ex_pause, m_ex.c.pause);
      check("ex_splitimm", bus.ex_splitimm, m_ex.c.splitimm);
      check("ex_aluop", bus.ex_aluop, m_ex.c.aluop);
      check("ex_pc", bus.ex_pc, m_ex.pc);
      check("ex_rd1", bus.ex_rd1, m_ex.rd1);
      check("ex_rd2", bus.ex_rd2, m_ex.rd2);
      check("ex_imm", bus.ex_imm, m_ex.imm);
      check("ex_rs1", bus.ex_rs1, m_ex.rs1);
      check("ex_rs2", bus.ex_rs2, m_ex.rs2);
      check("ex_rd", bus.ex_rd, m_ex.rd);
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      check("id_ready", bus.id_ready, exp_ready());
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic send(input bun_t b, output int n);
      present(b);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 20);
      check("send_accept", last_acc, 1);
      s_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic [XLEN-1:0] p;
      m_ex = '0; m_valid = 0; m_halted = 0; m_bub = 0;
      s_in = '0; s_valid = 0; s_exrdy = 1; s_flush = 0; last_acc = 0;
      next_pc = 32'h0000_1000;
      drive();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.id_ready, 0);
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // straight-line: ADDI x1,x0,5 ; ADD x2,x1,x1
      send(mk(c_op_immalu, 1, 0, 5, 5, 4'b0000), n);
      check("sl_addi_rd", bus.ex_rd, 1);
      check("sl_addi_op", bus.ex_aluop, 4'b0000);
      send(mk(c_op_regalu, 2, 1, 1, 0, 4'b0000), n);
      check("sl_add_lat", n, 1);
      check("sl_add_rd", bus.ex_rd, 2);
      check("sl_bubbles", bus.bubble_cnt, 0);

      // load-use: LW x3,0(x1) ; ADD x4,x3,x2
      send(mk(c_op_load, 3, 1, 0, 0, 4'b0000), n);
      send(mk(c_op_regalu, 4, 3, 2, 0, 4'b0000), n);
      check("lu_cycles", n, 2);
      check("lu_bubbles", bus.bubble_cnt, 1);

      // no false hazards: load to x0, immediate form ignoring rs2
      send(mk(c_op_load, 0, 1, 0, 0, 4'b0000), n);
      send(mk(c_op_regalu, 5, 0, 0, 0, 4'b0000), n);
      check("x0_cycles", n, 1);
      send(mk(c_op_load, 5, 1, 0, 0, 4'b0000), n);
      send(mk(c_op_immalu, 6, 7, 5, 1, 4'b0000), n);
      check("imm_cycles", n, 1);
      send(mk(c_op_load, 5, 1, 0, 0, 4'b0000), n);
      send(mk(c_op_store, 0, 8, 5, 0, 4'b0000), n);
      check("sw_cycles", n, 2);
      check("sw_bubbles", bus.bubble_cnt, 2);

      // backpressure for three cycles
      send(mk(c_op_regalu, 9, 1, 2, 0, 4'b0000), n);
      p = s_in.pc;
      present(mk(c_op_regalu, 10, 3, 4, 0, 4'b0000));
      s_exrdy = 1'b0;
      repeat (3) begin
         cycle();
         check("bp_pc", bus.ex_pc, p);
         check("bp_ready", bus.id_ready, 0);
      end
      s_exrdy = 1'b1;
      cycle();
      check("bp_resume", bus.ex_pc, p + 4);

      // flush squashes the presented instruction
      present(mk(c_op_store, 0, 1, 2, 0, 4'b0000));
      s_flush = 1'b1;
      cycle();
      check("fl_valid", bus.ex_valid, 0);
      check("fl_wr", bus.ex_writesreg, 0);
      check("fl_mw", bus.ex_memwrite, 0);
      check("fl_pc", bus.ex_pc, p + 4);
      present(mk(c_op_pause, 0, 0, 0, 0, 4'b0000));
      cycle();
      check("fl_pause_halt", bus.halted, 0);
      s_flush = 1'b0;
      s_valid = 1'b0;
      cycle();

      // randomized traffic
      for (int i = 0; i < 1200; i++) begin
         if (last_acc || !s_valid || s_flush) begin
            if ($urandom_range(0, 4) == 0) s_valid = 1'b0;
            else present(rand_instr());
         end
         s_exrdy = ($urandom_range(0, 3) != 0);
         s_flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      s_valid = 0; s_flush = 0; s_exrdy = 1;
      cycle();

      // drive the bubble counter into saturation
      for (int i = 0; i < 20; i++) begin
         send(mk(c_op_load, 3, 1, 0, 0, 4'b0000), n);
         send(mk(c_op_regalu, 4, 2, 3, 0, 4'b0000), n);
      end
      check("bub_sat", bus.bubble_cnt, CNT_MAX);

      // pause freezes the stage
      send(mk(c_op_pause, 0, 0, 0, 0, 4'b0000), n);
      check("halt_set", bus.halted, 1);
      check("halt_pause", bus.ex_pause, 1);
      present(rand_instr());
      for (int i = 0; i < 10; i++) begin
         s_exrdy = ($urandom_range(0, 1) == 1);
         cycle();
         check("halt_ready", bus.id_ready, 0);
         check("halt_sticky", bus.halted, 1);
      end

      // asynchronous reset in the middle of a cycle
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_halted", bus.halted, 0);
      check("arst_valid", bus.ex_valid, 0);
      check("arst_bubbles", bus.bubble_cnt, 0);
      check("arst_ready", bus.id_ready, 0);
      m_ex = '0; m_valid = 0; m_halted = 0; m_bub = 0;
      s_valid = 0; s_exrdy = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      send(mk(c_op_regalu, 7, 1, 2, 0, 4'b0000), n);
      check("post_rst_lat", n, 1);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
